// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the load/store alignment unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        logic [3:0] s;
        case (funct3[1:0])
            2'b00:   s = 4'd1;
            2'b01:   s = 4'd2;
            2'b10:   s = 4'd4;
            default: s = 4'd8;
        endcase
        return s;
    endfunction

    // Bits [7:0] cover the addressed doubleword, bits [15:8] the spill into the next one.
    function automatic logic [15:0] byte_mask(input logic [2:0] off, input logic [3:0] size);
        logic [15:0] ones;
        ones = (16'd1 << size) - 16'd1;
        return ones << off;
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) begin
            e[8*i +: 8] = {8{m[i]}};
        end
        return e;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: load extract/extend and store read-merge for either half of an access.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] hold,
    input  logic [63:0] wdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    input  logic        second,
    output logic [63:0] shifted,
    output logic [63:0] load_data,
    output logic [63:0] merged
);

    logic [3:0]  rem_s;
    logic [6:0]  lo_sh_s;
    logic [6:0]  hi_sh_s;
    logic [15:0] mask_s;
    logic [63:0] lo_mask_s;
    logic [63:0] hi_mask_s;
    logic [63:0] raw_s;

    // Shift amounts, lane masks, raw load bytes and merged store word.
    always_comb begin
        rem_s     = 4'd8 - {1'b0, off};
        lo_sh_s   = {1'b0, off, 3'b000};
        hi_sh_s   = {rem_s, 3'b000};
        mask_s    = byte_mask(off, size_of(funct3));
        lo_mask_s = expand_mask(mask_s[7:0]);
        hi_mask_s = expand_mask(mask_s[15:8]);
        shifted   = rdata >> lo_sh_s;
        if (second) begin
            raw_s  = hold | (rdata << hi_sh_s);
            merged = (rdata & ~hi_mask_s) | ((wdata >> hi_sh_s) & hi_mask_s);
        end else begin
            raw_s  = shifted;
            merged = (rdata & ~lo_mask_s) | ((wdata << lo_sh_s) & lo_mask_s);
        end
    end

    // Truncate to access size and sign- or zero-extend.
    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{56{raw_s[7]}}, raw_s[7:0]};
            F3_LH:   load_data = {{48{raw_s[15]}}, raw_s[15:0]};
            F3_LW:   load_data = {{32{raw_s[31]}}, raw_s[31:0]};
            F3_LD:   load_data = raw_s;
            F3_LBU:  load_data = {56'd0, raw_s[7:0]};
            F3_LHU:  load_data = {48'd0, raw_s[15:0]};
            F3_LWU:  load_data = {32'd0, raw_s[31:0]};
            default: load_data = raw_s;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// RV64I load/store alignment unit: doubleword-aligned memory accesses, boundary-crossing accesses split over two cycles.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemRead_M,
    input  logic            MemWrite_M,
    input  logic [2:0]      funct3_M,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] WriteData_M,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic [XLEN-1:0] LoadData_M,
    output logic            Stall_M,
    output logic            misalign_err
);

    state_t          state_r;
    logic [XLEN-1:0] req_addr_r;
    logic [XLEN-1:0] req_wdata_r;
    logic [XLEN-1:0] hold_r;
    logic [2:0]      req_f3_r;
    logic            req_store_r;

    logic            second_s;
    logic [XLEN-1:0] addr_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] base_s;
    logic [2:0]      f3_s;
    logic [3:0]      size_s;
    logic            cross_s;
    logic            req_s;
    logic            illegal_s;
    logic            blocked_s;
    logic            do_load_s;
    logic            do_store_s;
    logic            split_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] lane_load_s;
    logic [XLEN-1:0] merged_s;

    // In SECOND only the latched request drives the datapath.
    always_comb begin
        second_s = (state_r == SECOND);
        if (second_s) begin
            addr_s  = req_addr_r;
            wdata_s = req_wdata_r;
            f3_s    = req_f3_r;
        end else begin
            addr_s  = ALUResult_M;
            wdata_s = WriteData_M;
            f3_s    = funct3_M;
        end
        base_s  = {addr_s[XLEN-1:3], 3'b000};
        size_s  = size_of(f3_s);
        cross_s = ({1'b0, addr_s[2:0]} + size_s) > 4'd8;
    end

    // Request decode for a new access presented in IDLE.
    always_comb begin
        req_s     = MemRead_M | MemWrite_M;
        illegal_s = (MemRead_M & MemWrite_M)
                  | (MemRead_M & !(funct3_M inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU}))
                  | (MemWrite_M & !(funct3_M inside {F3_SB, F3_SH, F3_SW, F3_SD}));
        blocked_s  = illegal_s | (cross_s & !SPLIT_EN);
        do_load_s  = !second_s & MemRead_M & !blocked_s;
        do_store_s = !second_s & MemWrite_M & !blocked_s;
        split_s    = (do_load_s | do_store_s) & cross_s;
    end

    lsu_lane_align u_lane (
        .rdata     (mem_rdata),
        .hold      (hold_r),
        .wdata     (wdata_s),
        .off       (addr_s[2:0]),
        .funct3    (f3_s),
        .second    (second_s),
        .shifted   (shifted_s),
        .load_data (lane_load_s),
        .merged    (merged_s)
    );

    // Memory interface and pipeline handshake outputs, all forced quiet while rst_n is low.
    always_comb begin
        if (second_s) begin
            mem_addr = base_s + {{(XLEN-4){1'b0}}, 4'd8};
        end else begin
            mem_addr = base_s;
        end
        mem_wdata    = merged_s;
        mem_we       = rst_n & (do_store_s | (second_s & req_store_r));
        Stall_M      = rst_n & split_s;
        misalign_err = rst_n & !second_s & req_s & blocked_s;
        if (!rst_n) begin
            LoadData_M = '0;
        end else if (second_s & !req_store_r) begin
            LoadData_M = lane_load_s;
        end else if (do_load_s & !cross_s) begin
            LoadData_M = lane_load_s;
        end else begin
            LoadData_M = '0;
        end
    end

    // Split-access FSM with request latch and first-half load hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_addr_r  <= '0;
            req_wdata_r <= '0;
            req_f3_r    <= 3'd0;
            req_store_r <= 1'b0;
            hold_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (split_s) begin
                        req_addr_r  <= ALUResult_M;
                        req_wdata_r <= WriteData_M;
                        req_f3_r    <= funct3_M;
                        req_store_r <= MemWrite_M;
                        hold_r      <= shifted_s;
                        state_r     <= SECOND;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                SECOND:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed vector table, hand sequences and a random run against a byte-array memory model.
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [2:0]  funct3_M;
    logic [63:0] ALUResult_M;
    logic [63:0] WriteData_M;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] LoadData_M;
    logic        Stall_M;
    logic        misalign_err;

    logic [63:0] rdata0;
    logic [63:0] mem_addr0;
    logic [63:0] mem_wdata0;
    logic        mem_we0;
    logic [63:0] LoadData0;
    logic        Stall0;
    logic        err0;

    logic [63:0] mem [0:15];
    logic [7:0]  ref_mem [0:127];

    int n_cmp;
    int n_bad;

    lsu_align #(.XLEN(64), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .funct3_M(funct3_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .LoadData_M(LoadData_M), .Stall_M(Stall_M), .misalign_err(misalign_err)
    );

    lsu_align #(.XLEN(64), .SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .funct3_M(funct3_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .mem_rdata(rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .LoadData_M(LoadData0), .Stall_M(Stall0), .misalign_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[6:3]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[6:3]] <= mem_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%016h required=0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        int          sz;
        logic [63:0] v;
        logic [63:0] ones;
        sz   = 1 << f3[1:0];
        v    = 64'd0;
        ones = '1;
        for (int i = 0; i < sz; i++) begin
            v = v | (64'(ref_mem[(int'(a[6:0]) + i) % 128]) << (8 * i));
        end
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (ones << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int sz;
        sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) begin
            ref_mem[(int'(a[6:0]) + i) % 128] = wd[8*i +: 8];
        end
    endtask

    // Presents one request from just after a rising edge and follows it until the stall clears.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input bit scr, output logic [63:0] ld,
                         output int stalls, output logic err, output logic we_any);
        bit done;
        MemRead_M = rd; MemWrite_M = wr; funct3_M = f3; ALUResult_M = addr; WriteData_M = wd;
        stalls = 0; err = 1'b0; we_any = 1'b0; ld = 64'd0; done = 1'b0;
        for (int c = 0; c < 4 && !done; c++) begin
            @(negedge clk);
            err    = err | misalign_err;
            we_any = we_any | mem_we;
            if (Stall_M) begin
                stalls++;
                @(posedge clk); #1;
                if (scr) begin
                    ALUResult_M = {$urandom(), $urandom()};
                    WriteData_M = {$urandom(), $urandom()};
                    funct3_M    = 3'($urandom_range(0, 7));
                    MemRead_M   = 1'($urandom_range(0, 1));
                    MemWrite_M  = 1'($urandom_range(0, 1));
                end
            end else begin
                ld   = LoadData_M;
                done = 1'b1;
            end
        end
        check("op_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_ld;
        int          exp_stall;
        logic        exp_err;
        bit          scr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp_ld, input int exp_stall,
                       input logic exp_err, input bit scr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_ld = exp_ld; v.exp_stall = exp_stall; v.exp_err = exp_err; v.scr = scr;
        vq.push_back(v);
    endtask

    initial begin
        logic [63:0] ld;
        logic [63:0] pre;
        logic        err;
        logic        we_any;
        int          stalls;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; funct3_M = 3'd0;
        ALUResult_M = 64'd0; WriteData_M = 64'd0; rdata0 = 64'h0F1E2D3C4B5A6978;
        for (int w = 0; w < 16; w++) mem[w] = 64'd0;
        for (int b = 0; b < 128; b++) ref_mem[b] = 8'd0;
        pre = 64'h0123456789ABCDEF;
        mem[1] = pre;
        for (int i = 0; i < 8; i++) ref_mem[8 + i] = pre[8*i +: 8];

        // Requests presented while in reset must have no effect.
        @(posedge clk); #1;
        MemWrite_M = 1'b1; funct3_M = 3'd2; ALUResult_M = 64'h6; WriteData_M = 64'hFFFF_FFFF;
        @(negedge clk);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_stall", 64'(Stall_M), 64'd0);
        @(posedge clk); #1;
        MemRead_M = 1'b1; funct3_M = 3'd3; ALUResult_M = 64'h8;
        @(negedge clk);
        check("rst_err", 64'(misalign_err), 64'd0);
        @(posedge clk); #1;
        MemWrite_M = 1'b0;
        @(negedge clk);
        check("rst_ld", LoadData_M, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; MemRead_M = 1'b0;
        @(posedge clk); #1;

        add(1'b0, 1'b1, 3'd3, 64'h10, 64'hABCDE1234567890F, 64'd0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 64'hABCDE1234567890F, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd3, 64'h10, 64'h1111111111111111, 64'd0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd0, 64'h13, 64'h5580, 64'd0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 64'h1111111180111111, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd4, 64'h13, 64'd0, 64'h80, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd2, 64'h1E, 64'hDEADBEEF, 64'd0, 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd3, 64'h18, 64'd0, 64'hBEEF000000000000, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd3, 64'h20, 64'd0, 64'h000000000000DEAD, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd6, 64'h1E, 64'd0, 64'h00000000DEADBEEF, 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd2, 64'h1E, 64'd0, 64'hFFFFFFFFDEADBEEF, 1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd0, 64'h1F, 64'h34, 64'd0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd0, 64'h20, 64'h92, 64'd0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd1, 64'h1F, 64'd0, 64'hFFFFFFFFFFFF9234, 1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd5, 64'h1F, 64'd0, 64'h9234, 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd3, 64'h10, 64'hFFFF, 64'd0, 0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 3'd4, 64'h10, 64'hFFFF, 64'd0, 0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd7, 64'h10, 64'd0, 64'd0, 0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd3, 64'h10, 64'd0, 64'h1111111180111111, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hA55A, 64'd0, 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'hFFFFFFFFFFFFA55A, 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd4, 64'h0, 64'd0, 64'hA5, 0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            do_op(vq[i].rd, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].wdata, vq[i].scr, ld, stalls, err, we_any);
            check($sformatf("vec%0d_stall", i), 64'(stalls), 64'(vq[i].exp_stall));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vq[i].exp_err));
            check($sformatf("vec%0d_we", i), 64'(we_any), 64'(vq[i].wr & !vq[i].exp_err));
            if (vq[i].rd && !vq[i].exp_err) check($sformatf("vec%0d_ld", i), ld, vq[i].exp_ld);
            if (vq[i].wr && !vq[i].exp_err) ref_store(vq[i].f3, vq[i].addr, vq[i].wdata);
        end

        // Reset during the second half of a split SW: only the first half lands.
        MemWrite_M = 1'b1; funct3_M = 3'd2; ALUResult_M = 64'h2E; WriteData_M = 64'h01020304;
        @(negedge clk);
        check("rsplit_stall", 64'(Stall_M), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rsplit_we", 64'(mem_we), 64'd0);
        check("rsplit_stall2", 64'(Stall_M), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; MemWrite_M = 1'b0;
        ref_mem[8'h2E] = 8'h04; ref_mem[8'h2F] = 8'h03;
        do_op(1'b1, 1'b0, 3'd3, 64'h28, 64'd0, 1'b0, ld, stalls, err, we_any);
        check("rsplit_ld_lo", ld, 64'h0304000000000000);
        check("rsplit_ld_lo_stall", 64'(stalls), 64'd0);
        do_op(1'b1, 1'b0, 3'd3, 64'h30, 64'd0, 1'b0, ld, stalls, err, we_any);
        check("rsplit_ld_hi", ld, 64'd0);

        // SPLIT_EN=0 instance: crossing access flagged, aligned accesses work.
        MemRead_M = 1'b1; funct3_M = 3'd3; ALUResult_M = 64'h1C;
        @(negedge clk);
        check("nosplit_err", 64'(err0), 64'd1);
        check("nosplit_we", 64'(mem_we0), 64'd0);
        check("nosplit_stall", 64'(Stall0), 64'd0);
        @(posedge clk); #1;
        ALUResult_M = 64'h18;
        @(negedge clk);
        check("nosplit_al_err", 64'(err0), 64'd0);
        check("nosplit_al_ld", LoadData0, 64'h0F1E2D3C4B5A6978);
        check("nosplit_al_addr", mem_addr0, 64'h18);
        @(posedge clk); #1;
        MemRead_M = 1'b0; MemWrite_M = 1'b1; ALUResult_M = 64'h40; WriteData_M = 64'h5566778899AABBCC;
        @(negedge clk);
        check("nosplit_sd_we", 64'(mem_we0), 64'd1);
        check("nosplit_sd_wdata", mem_wdata0, 64'h5566778899AABBCC);
        @(posedge clk); #1;
        MemWrite_M = 1'b0;
        ref_store(3'd3, 64'h40, 64'h5566778899AABBCC);

        // Random accesses against the byte-array model.
        for (int it = 0; it < 250; it++) begin
            int          kind;
            int          sub;
            int          sz;
            logic        rd;
            logic        wr;
            logic        legal;
            logic        crs;
            logic [2:0]  f3;
            logic [63:0] a;
            logic [63:0] wd;
            logic [63:0] exp_ld;
            bit          scr;
            kind = $urandom_range(0, 9);
            a    = {$urandom(), $urandom()};
            wd   = {$urandom(), $urandom()};
            scr  = 1'($urandom_range(0, 1));
            if (kind < 4) begin
                rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 3));
            end else if (kind < 9) begin
                rd = 1'b1; wr = 1'b0; f3 = 3'($urandom_range(0, 6));
            end else begin
                sub = $urandom_range(0, 2);
                if (sub == 0) begin
                    rd = 1'b1; wr = 1'b1; f3 = 3'($urandom_range(0, 7));
                end else if (sub == 1) begin
                    rd = 1'b1; wr = 1'b0; f3 = 3'd7;
                end else begin
                    rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(4, 7));
                end
            end
            legal  = !(rd && wr) && !(rd && f3 == 3'd7) && !(wr && f3[2]);
            sz     = 1 << f3[1:0];
            crs    = (int'(a[2:0]) + sz) > 8;
            exp_ld = ref_load(f3, a);
            do_op(rd, wr, f3, a, wd, scr, ld, stalls, err, we_any);
            check($sformatf("rnd%0d_stall", it), 64'(stalls), 64'(legal && crs));
            check($sformatf("rnd%0d_err", it), 64'(err), 64'(!legal));
            check($sformatf("rnd%0d_we", it), 64'(we_any), 64'(legal && wr));
            if (legal && rd) check($sformatf("rnd%0d_ld", it), ld, exp_ld);
            if (legal && wr) ref_store(f3, a, wd);
        end

        for (int w = 0; w < 16; w++) begin
            logic [63:0] e;
            for (int b = 0; b < 8; b++) e[8*b +: 8] = ref_mem[8*w + b];
            check($sformatf("mem_word%0d", w), mem[w], e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
